uart_tx_fifo: RTL and testbench

Parametrised UART transmitter with an integrated write FIFO, configurable frame format (5–8 data bits, optional odd/even parity, 1–2 stop bits), and back-to-back frame streaming. It sits between the coincidence-processor readout/control logic and the board UART pin. Producers push bytes without waiting on the serialiser; frames leave with no idle gap while the FIFO holds data.

---
 rtl/uart_tx_fifo.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small write FIFO; frames stream back-to-back while data is queued.
// Frame format (data bits, parity, stop bits) and bit period are fixed by parameters.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_WIDTH = 1,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done
);

  localparam int BAUD_CNT = CLK_FREQ / BAUD_RATE;
  localparam int CW       = $clog2(BAUD_CNT);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int LW       = AW + 1;

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_CNT - 1);
  localparam logic [2:0]    DATA_LAST = 3'(DATA_WIDTH - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_WIDTH - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_WIDTH) - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          full_q, overflow_q;
  logic          push, pop;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;
  logic          done_q, done_d;
  logic          load;
  logic          baud_done;
  logic [7:0]    head;

  // The full flag used for acceptance is the registered one, so a same-cycle pop never rescues a write.
  assign push    = wr_en && !full_q;
  assign level_d = level_q + LW'(push) - LW'(pop);
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q    <= level_d;
      full_q     <= (level_d == DEPTH_L);
      overflow_q <= wr_en && full_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

  assign baud_done = (cnt_q == BAUD_LAST);

  // txd_d is only ever changed on a bit boundary, so the line register switches once per bit period.
  always_comb begin
    state_d = state_q;
    cnt_d   = baud_done ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    done_d  = 1'b0;
    load    = 1'b0;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (level_q != '0) load = 1'b1;
      end
      START: begin
        if (baud_done) begin
          state_d = DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = PAR;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
      PAR: begin
        if (baud_done) begin
          state_d = STOP;
          bit_d   = '0;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          if (bit_q == STOP_LAST) begin
            done_d  = 1'b1;
            bit_d   = '0;
            if (level_q != '0) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      pop     = 1'b1;
      state_d = START;
      cnt_d   = '0;
      txd_d   = 1'b0;
      shift_d = head;
      par_d   = (^(head & DATA_MASK)) ^ PAR_ODD;
    end
  end

  assign full     = full_q;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign txd      = txd_q;
  assign busy     = (state_q != IDLE);
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: five instances with different frame formats share one clock.
// Expected line waveforms come from a frame model built directly from the data byte and format.
module tb_uart_tx_fifo;

  localparam int BAUD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       wr_en_v     [5];
  logic [7:0] wr_data_v   [5];
  logic       txd_v       [5];
  logic       busy_v      [5];
  logic       tx_done_v   [5];
  logic       overflow_v  [5];
  logic       full_v      [5];
  logic [4:0] level_v     [4];
  logic [2:0] level_e;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  uart_tx_fifo #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_WIDTH(8), .STOP_WIDTH(1), .PARITY(0), .FIFO_DEPTH(16)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_v[0]), .wr_data(wr_data_v[0]), .full(full_v[0]), .level(level_v[0]),
    .overflow(overflow_v[0]), .txd(txd_v[0]), .busy(busy_v[0]), .tx_done(tx_done_v[0]));
  uart_tx_fifo #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_WIDTH(8), .STOP_WIDTH(1), .PARITY(1), .FIFO_DEPTH(16)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_v[1]), .wr_data(wr_data_v[1]), .full(full_v[1]), .level(level_v[1]),
    .overflow(overflow_v[1]), .txd(txd_v[1]), .busy(busy_v[1]), .tx_done(tx_done_v[1]));
  uart_tx_fifo #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_WIDTH(8), .STOP_WIDTH(1), .PARITY(2), .FIFO_DEPTH(16)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_v[2]), .wr_data(wr_data_v[2]), .full(full_v[2]), .level(level_v[2]),
    .overflow(overflow_v[2]), .txd(txd_v[2]), .busy(busy_v[2]), .tx_done(tx_done_v[2]));
  uart_tx_fifo #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_WIDTH(5), .STOP_WIDTH(2), .PARITY(0), .FIFO_DEPTH(16)) u_5n2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_v[3]), .wr_data(wr_data_v[3]), .full(full_v[3]), .level(level_v[3]),
    .overflow(overflow_v[3]), .txd(txd_v[3]), .busy(busy_v[3]), .tx_done(tx_done_v[3]));
  uart_tx_fifo #(.CLK_FREQ(160), .BAUD_RATE(10), .DATA_WIDTH(8), .STOP_WIDTH(1), .PARITY(0), .FIFO_DEPTH(4)) u_dep4 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_v[4]), .wr_data(wr_data_v[4]), .full(full_v[4]), .level(level_e),
    .overflow(overflow_v[4]), .txd(txd_v[4]), .busy(busy_v[4]), .tx_done(tx_done_v[4]));

  function automatic int cfg_dw(int idx);
    return (idx == 3) ? 5 : 8;
  endfunction

  function automatic int cfg_par(int idx);
    return (idx == 1) ? 1 : (idx == 2) ? 2 : 0;
  endfunction

  function automatic int cfg_sw(int idx);
    return (idx == 3) ? 2 : 1;
  endfunction

  function automatic int get_level(int idx);
    return (idx == 4) ? int'(level_e) : int'(level_v[idx]);
  endfunction

  function automatic int frame_len(int idx);
    return 1 + cfg_dw(idx) + ((cfg_par(idx) != 0) ? 1 : 0) + cfg_sw(idx);
  endfunction

  // Line value of bit k of a frame carrying 'data', derived from the frame format alone.
  function automatic logic expected_bit(int idx, logic [7:0] data, int k);
    int dw = cfg_dw(idx);
    int ones = 0;
    if (k == 0) return 1'b0;
    if (k <= dw) return data[k-1];
    if (cfg_par(idx) != 0 && k == dw + 1) begin
      for (int i = 0; i < dw; i++) ones += int'(data[i]);
      if (cfg_par(idx) == 1) return ((ones % 2) == 0);
      return ((ones % 2) == 1);
    end
    return 1'b1;
  endfunction

  task automatic write_byte(int idx, logic [7:0] data);
    wr_en_v[idx]   = 1'b1;
    wr_data_v[idx] = data;
    @(negedge clk);
    wr_en_v[idx]   = 1'b0;
  endtask

  task automatic wait_start(int idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (txd_v[idx] === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL start_timeout dut%0d: txd stayed high, expected a start bit", idx);
    end
  endtask

  // Entered on the first cycle of a start bit; leaves on the cycle where tx_done must be high.
  task automatic check_frame(int idx, logic [7:0] data);
    int n = frame_len(idx);
    logic b;
    for (int k = 0; k < n; k++) begin
      b = expected_bit(idx, data, k);
      checks++;
      if (txd_v[idx] !== b) begin
        errors++;
        $display("[TB] FAIL bit_first dut%0d data=%02h bit%0d: txd=%b expected %b", idx, data, k, txd_v[idx], b);
      end
      repeat (BAUD - 1) @(negedge clk);
      checks++;
      if (txd_v[idx] !== b) begin
        errors++;
        $display("[TB] FAIL bit_last dut%0d data=%02h bit%0d: txd=%b expected %b", idx, data, k, txd_v[idx], b);
      end
      if (k == n - 1) begin
        checks++;
        if (tx_done_v[idx] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL tx_done_early dut%0d data=%02h: tx_done=%b expected 0", idx, data, tx_done_v[idx]);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (tx_done_v[idx] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL tx_done_pulse dut%0d data=%02h: tx_done=%b expected 1", idx, data, tx_done_v[idx]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks += 6;
      if (txd_v[i] !== 1'b1)      begin errors++; $display("[TB] FAIL reset_txd dut%0d: %b expected 1", i, txd_v[i]); end
      if (busy_v[i] !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy dut%0d: %b expected 0", i, busy_v[i]); end
      if (tx_done_v[i] !== 1'b0)  begin errors++; $display("[TB] FAIL reset_tx_done dut%0d: %b expected 0", i, tx_done_v[i]); end
      if (overflow_v[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow dut%0d: %b expected 0", i, overflow_v[i]); end
      if (full_v[i] !== 1'b0)     begin errors++; $display("[TB] FAIL reset_full dut%0d: %b expected 0", i, full_v[i]); end
      if (get_level(i) != 0)      begin errors++; $display("[TB] FAIL reset_level dut%0d: %0d expected 0", i, get_level(i)); end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_8n1();
    wr_en_v[0] = 1'b1;
    wr_data_v[0] = 8'h55;
    @(negedge clk);
    wr_en_v[0] = 1'b0;
    checks += 3;
    if (get_level(0) != 1) begin errors++; $display("[TB] FAIL latency_level: %0d expected 1", get_level(0)); end
    if (txd_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL latency_txd_idle: %b expected 1", txd_v[0]); end
    if (busy_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL latency_busy_idle: %b expected 0", busy_v[0]); end
    @(negedge clk);
    checks += 2;
    if (busy_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL start_busy: %b expected 1", busy_v[0]); end
    if (get_level(0) != 0) begin errors++; $display("[TB] FAIL start_level: %0d expected 0", get_level(0)); end
    check_frame(0, 8'h55);
    checks++;
    if (busy_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL end_busy: %b expected 0", busy_v[0]); end
    @(negedge clk);
    checks += 2;
    if (tx_done_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL tx_done_width: %b expected 0", tx_done_v[0]); end
    if (txd_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL idle_txd: %b expected 1", txd_v[0]); end
  endtask

  task automatic send_and_check(int idx, logic [7:0] data);
    bit ok;
    fork
      write_byte(idx, data);
      begin
        wait_start(idx, ok);
        if (ok) check_frame(idx, data);
      end
    join
    @(negedge clk);
  endtask

  task automatic test_parity();
    for (int idx = 1; idx <= 2; idx++) begin
      send_and_check(idx, 8'h07);
      for (int r = 0; r < 2; r++) send_and_check(idx, 8'($urandom));
    end
  endtask

  task automatic test_five_two();
    send_and_check(3, 8'hE3);
    for (int r = 0; r < 2; r++) send_and_check(3, 8'($urandom));
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] seq [3];
    seq[0] = 8'hA1; seq[1] = 8'hB2; seq[2] = 8'hC3;
    fork
      begin
        wr_en_v[0] = 1'b1;
        wr_data_v[0] = seq[0];
        @(negedge clk);
        checks++;
        if (get_level(0) != 1) begin errors++; $display("[TB] FAIL stream_level1: %0d expected 1", get_level(0)); end
        wr_data_v[0] = seq[1];
        @(negedge clk);
        checks++;
        if (get_level(0) != 1) begin errors++; $display("[TB] FAIL stream_level2: %0d expected 1", get_level(0)); end
        wr_data_v[0] = seq[2];
        @(negedge clk);
        wr_en_v[0] = 1'b0;
        checks++;
        if (get_level(0) != 2) begin errors++; $display("[TB] FAIL stream_peak: %0d expected 2", get_level(0)); end
      end
      begin
        wait_start(0, ok);
        if (ok) for (int i = 0; i < 3; i++) check_frame(0, seq[i]);
      end
    join
    checks += 2;
    if (get_level(0) != 0) begin errors++; $display("[TB] FAIL stream_end_level: %0d expected 0", get_level(0)); end
    if (busy_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL stream_end_busy: %b expected 0", busy_v[0]); end
    @(negedge clk);
  endtask

  task automatic test_random_stream();
    bit ok;
    int n = $urandom_range(3, 6);
    exp_q.delete();
    fork
      for (int i = 0; i < n; i++) begin
        logic [7:0] d = 8'($urandom);
        exp_q.push_back(d);
        write_byte(0, d);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      begin
        wait_start(0, ok);
        if (ok) for (int i = 0; i < n; i++) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL rand_queue: model queue empty, expected byte %0d", i);
          end else begin
            check_frame(0, exp_q.pop_front());
          end
        end
      end
    join
    checks++;
    if (busy_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL rand_end_busy: %b expected 0", busy_v[0]); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    bit ok;
    int mlevel = 0;
    bit midle = 1'b1;
    bit mfull = 1'b0;
    bit prev_full;
    bit exp_ovf;
    int lows = 0;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          wr_en_v[4] = 1'b1;
          wr_data_v[4] = 8'(i);
          @(negedge clk);
          prev_full = mfull;
          if (midle && mlevel > 0) begin
            midle = 1'b0;
            mlevel--;
          end
          if (!prev_full) begin
            mlevel++;
            exp_q.push_back(8'(i));
            exp_ovf = 1'b0;
          end else begin
            exp_ovf = 1'b1;
          end
          mfull = (mlevel == 4);
          checks += 3;
          if (get_level(4) != mlevel) begin errors++; $display("[TB] FAIL ovf_level w%0d: %0d expected %0d", i, get_level(4), mlevel); end
          if (full_v[4] !== mfull) begin errors++; $display("[TB] FAIL ovf_full w%0d: %b expected %b", i, full_v[4], mfull); end
          if (overflow_v[4] !== exp_ovf) begin errors++; $display("[TB] FAIL ovf_pulse w%0d: %b expected %b", i, overflow_v[4], exp_ovf); end
        end
        wr_en_v[4] = 1'b0;
        @(negedge clk);
        checks++;
        if (overflow_v[4] !== 1'b0) begin errors++; $display("[TB] FAIL ovf_pulse_width: %b expected 0", overflow_v[4]); end
      end
      begin
        wait_start(4, ok);
        if (ok) for (int j = 0; j < 5; j++) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL ovf_queue: model queue empty at frame %0d", j);
          end else begin
            check_frame(4, exp_q.pop_front());
          end
        end
      end
    join
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (txd_v[4] !== 1'b1) lows++;
    end
    checks += 4;
    if (lows != 0) begin errors++; $display("[TB] FAIL ovf_dropped_sent: txd low %0d cycles expected 0", lows); end
    if (busy_v[4] !== 1'b0) begin errors++; $display("[TB] FAIL ovf_end_busy: %b expected 0", busy_v[4]); end
    if (get_level(4) != 0) begin errors++; $display("[TB] FAIL ovf_end_level: %0d expected 0", get_level(4)); end
    if (full_v[4] !== 1'b0) begin errors++; $display("[TB] FAIL ovf_end_full: %b expected 0", full_v[4]); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int lows = 0;
    int lvl_bad = 0;
    fork
      begin
        write_byte(0, 8'hFF);
        write_byte(0, 8'h11);
        write_byte(0, 8'h22);
      end
      wait_start(0, ok);
    join
    repeat (BAUD * 3 + 5) @(negedge clk);
    checks++;
    if (get_level(0) != 2) begin errors++; $display("[TB] FAIL rst_pre_level: %0d expected 2", get_level(0)); end
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (txd_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL rst_async_txd: %b expected 1", txd_v[0]); end
    if (get_level(0) != 0) begin errors++; $display("[TB] FAIL rst_async_level: %0d expected 0", get_level(0)); end
    if (busy_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_busy: %b expected 0", busy_v[0]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (txd_v[0] !== 1'b1) lows++;
      if (get_level(0) != 0) lvl_bad++;
    end
    checks += 2;
    if (lows != 0) begin errors++; $display("[TB] FAIL rst_quiet_txd: low %0d cycles expected 0", lows); end
    if (lvl_bad != 0) begin errors++; $display("[TB] FAIL rst_quiet_level: nonzero %0d cycles expected 0", lvl_bad); end
    send_and_check(0, 8'h3C);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 5; i++) begin
      wr_en_v[i]   = 1'b0;
      wr_data_v[i] = 8'h00;
    end
    test_reset();
    test_single_8n1();
    test_parity();
    test_five_two();
    test_back_to_back();
    test_random_stream();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
